mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide memory port (separate raddr/waddr, mem_write strobe, mem_ready)
//  between two requesters: port 0 (cpu) and port 1 (host loader/debug monitor).
//  Serialises one byte access at a time, round-robin on contention, per-port ack/err pulses.
//  Sits between the requesters and the memory; the memory's ports connect here directly.
// PARAMETERS
//  ADDR_WIDTH  9    memory address width in bits
//  TIMEOUT     15   max cycles in RSAMPLE waiting for mem_ready before err; >=1, fits 8 bits
// PORTS
//  clk           in   1           clock, all logic on rising edge
//  reset         in   1           synchronous, active-high
//  rN_req        in   1           N=0,1: access request; hold stable until rN_ack
//  rN_we         in   1           1=write, 0=read; sampled with req
//  rN_addr       in   ADDR_WIDTH  byte address
//  rN_wdata      in   8           write data
//  rN_ack        out  1           one-cycle pulse: access complete
//  rN_err        out  1           one-cycle pulse, with rN_ack: read timed out
//  rN_rdata      out  8           read data, valid from rN_ack until the next read ack on port N
//  mem_raddr     out  ADDR_WIDTH  memory read address
//  mem_waddr     out  ADDR_WIDTH  memory write address
//  mem_data_in   out  8           data to memory
//  mem_write     out  1           write strobe, one cycle per write
//  mem_data_out  in   8           data from memory, valid 2 edges after mem_raddr is registered
//  mem_ready     in   1           memory read data valid
//  busy          out  1           high in every state except IDLE
//  owner         out  1           port of the current or last grant
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except owner=1. Counter cleared. Reset mid-access
//   aborts it; mem_write is 0 from the next cycle, no ack is issued.
//  All outputs are registered.
//  States: IDLE, WRITE, RWAIT, RSAMPLE, ACK.
//  IDLE: if exactly one req, grant it. If both, grant the port != owner.
//   On grant: owner<=N. Write: mem_waddr<=addr, mem_data_in<=wdata, mem_write<=1 -> WRITE.
//   Read: mem_raddr<=addr, cnt<=0 -> RWAIT. No req: stay in IDLE, outputs hold.
//  WRITE: mem_write<=0, rN_ack<=1 -> ACK.
//  RWAIT: -> RSAMPLE. This is the fixed one-cycle RAM latency.
//  RSAMPLE: if mem_ready: rN_rdata<=mem_data_out, rN_ack<=1 -> ACK.
//   Else if cnt==TIMEOUT-1: rN_rdata<=8'h00, rN_ack<=1, rN_err<=1 -> ACK.
//   Else cnt<=cnt+1, stay.
//  ACK: ack/err<=0 -> IDLE. Requester drops req on the edge ending the ack cycle.
//   The arbiter does not sample req in ACK, so a request is never double-granted.
//  Latency from the IDLE edge that accepts req to the ack-high cycle:
//   write 2 cycles; read 3 cycles with mem_ready high; read timeout TIMEOUT+2 cycles.
//  Requests arriving while busy wait. A waiting port wins the next tie, so neither port starves.
//  mem_raddr/mem_waddr/mem_data_in hold their last values when idle.
//  Only the granted port's ack/err/rdata change; the other port's outputs are untouched.
//  Changing req/we/addr/wdata before ack is a protocol violation; behaviour is undefined.
// TESTING
//  1 Reset: hold reset 2 cycles mid-write -> all outputs 0, owner=1, mem_write 0 next cycle.
//  2 r0 write addr 9'h010 data 8'hA5 -> mem_write for 1 cycle with waddr 010, data A5;
//    r0_ack 2 cycles after accept; r1 outputs idle.
//  3 r1 read addr 9'h010 with mem_ready=1, RAM holds A5 -> r1_rdata=A5, r1_ack 3 cycles
//    after accept, r1_err=0.
//  4 r0 and r1 req same cycle from reset -> r0 served first, r1 next; repeated contention
//    alternates 0,1,0,1.
//  5 Read with mem_ready held 0, TIMEOUT=15 -> r0_ack and r0_err together 17 cycles after
//    accept, rdata=00; next request is served normally.
//  6 r1 streams back-to-back writes while r0 requests a read -> r0 granted on the next IDLE;
//    r1 write count per r0 grant <= 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a byte-wide memory with registered read latency.
// One access in flight at a time; per-port ack/err pulses and held read data.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req_i,
  input  logic                  r0_we_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [7:0]            r0_wdata_i,
  output logic                  r0_ack_o,
  output logic                  r0_err_o,
  output logic [7:0]            r0_rdata_o,
  input  logic                  r1_req_i,
  input  logic                  r1_we_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [7:0]            r1_wdata_i,
  output logic                  r1_ack_o,
  output logic                  r1_err_o,
  output logic [7:0]            r1_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [7:0]            mem_data_in_o,
  output logic                  mem_write_o,
  input  logic [7:0]            mem_data_out_i,
  input  logic                  mem_ready_i,
  output logic                  busy_o,
  output logic                  owner_o
);

  typedef enum logic [2:0] {IDLE, WRITE, RWAIT, RSAMPLE, ACK} state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic [1:0]              ack_q, ack_d;
  logic [1:0]              err_q, err_d;
  logic [7:0]              rdata0_q, rdata0_d;
  logic [7:0]              rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [7:0]              dataIn_q, dataIn_d;
  logic                    write_q, write_d;
  logic                    busy_q, busy_d;

  logic                    anyReq;
  logic                    selPort;
  logic                    selWe;
  logic [ADDR_WIDTH-1:0]   selAddr;
  logic [7:0]              selWdata;

  // On a tie the port that did not own the last grant wins, so a waiting port never starves.
  assign anyReq   = r0_req_i | r1_req_i;
  assign selPort  = (r0_req_i & r1_req_i) ? ~owner_q : r1_req_i;
  assign selWe    = selPort ? r1_we_i    : r0_we_i;
  assign selAddr  = selPort ? r1_addr_i  : r0_addr_i;
  assign selWdata = selPort ? r1_wdata_i : r0_wdata_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b1;
      ack_q    <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      dataIn_q <= '0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      dataIn_q <= dataIn_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (anyReq) state_d = selWe ? WRITE : RWAIT;
      WRITE:   state_d = ACK;
      RWAIT:   state_d = RSAMPLE;
      RSAMPLE: if (mem_ready_i || cnt_q == LastCnt) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    ack_d    = '0;
    err_d    = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    dataIn_d = dataIn_q;
    write_d  = 1'b0;
    busy_d   = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          owner_d = selPort;
          if (selWe) begin
            waddr_d  = selAddr;
            dataIn_d = selWdata;
            write_d  = 1'b1;
          end else begin
            raddr_d = selAddr;
            cnt_d   = '0;
          end
        end
      end
      WRITE: ack_d[owner_q] = 1'b1;
      RSAMPLE: begin
        // A timed-out read still acks, with zero data and the error flag.
        if (mem_ready_i || cnt_q == LastCnt) begin
          ack_d[owner_q] = 1'b1;
          err_d[owner_q] = ~mem_ready_i;
          if (owner_q) rdata1_d = mem_ready_i ? mem_data_out_i : 8'h00;
          else         rdata0_d = mem_ready_i ? mem_data_out_i : 8'h00;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign r0_ack_o      = ack_q[0];
  assign r1_ack_o      = ack_q[1];
  assign r0_err_o      = err_q[0];
  assign r1_err_o      = err_q[1];
  assign r0_rdata_o    = rdata0_q;
  assign r1_rdata_o    = rdata1_q;
  assign mem_raddr_o   = raddr_q;
  assign mem_waddr_o   = waddr_q;
  assign mem_data_in_o = dataIn_q;
  assign mem_write_o   = write_q;
  assign busy_o        = busy_q;
  assign owner_o       = owner_q;

endmodule
